// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data memory responder.
package dmem_resp_pkg;

    // Request handshake states; WAIT is only used when DMEM_RESP_WAIT_EN is defined.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } state_e;

    // Read data returned for an access outside the memory array.
    localparam logic [31:0] DMEM_OOR_DATA = 32'hDEADBEEF;

    // Request fields captured on the grant cycle.
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_be_merge.sv
// Byte-lane merge: each enabled byte is taken from the new word, the rest from the old word.
module dmem_be_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [3:0]  be_i,
    output logic [31:0] merged_o
);

    // Select each byte lane independently.
    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: single-outstanding request/grant/rvalid slave backed by a word array.
// Optional feature macro DMEM_RESP_WAIT_EN: builds the WAIT state and counter so that
// WAIT_CYCLES idle cycles are inserted before each grant. Without it, grant follows request
// combinationally and WAIT_CYCLES is ignored.
// The response cycle is the cycle in GRANT state; the write commits at the end of that cycle,
// so a reset arriving during it aborts both the rvalid and the write.
module data_mem_responder
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        err_o,
    output logic        wr_evt_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_be_o
);

    localparam int          IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_Q = 4'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic              gnt;
    dmem_req_t         req_q, req_d;
    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0]  idx;
    logic              oor;
    logic              rsp;
    logic              mem_we;
    logic [31:0]       rd_word;
    logic [31:0]       merged;

`ifdef DMEM_RESP_WAIT_EN
    logic [3:0]        cnt_q, cnt_d;

    // Next-state and grant decode with programmable wait before each grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        case (state_q)
            WAIT: begin
                if (!data_req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= WAIT_Q) begin
                    gnt     = 1'b1;
                    state_d = GRANT;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            default: begin
                if (!data_req_i) begin
                    state_d = IDLE;
                end else if (WAIT_Q == 4'd0) begin
                    gnt     = 1'b1;
                    state_d = GRANT;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 4'd1;
                end
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic unused_wait_cfg;
    assign unused_wait_cfg = ^WAIT_Q;

    // Zero-wait build: every request is granted in the cycle it is presented.
    always_comb begin
        gnt     = data_req_i;
        state_d = data_req_i ? GRANT : IDLE;
    end

    // State register.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    assign data_gnt_o = gnt & ~rst_i;

    // Capture the request fields on the grant cycle, hold them otherwise.
    always_comb begin
        req_d = req_q;
        if (gnt) begin
            req_d = '{we: data_we_i, be: data_be_i, addr: data_addr_i, wdata: data_wdata_i};
        end
    end

    // Captured request is plain data; its use is qualified by the FSM state.
    always_ff @(posedge clk) begin
        req_q <= req_d;
    end

    assign rsp     = (state_q == GRANT);
    assign idx     = req_q.addr[IDX_W+1:2];
    assign oor     = |req_q.addr[31:IDX_W+2];
    assign rd_word = mem_q[idx];
    assign mem_we  = rsp & req_q.we & ~oor;

    dmem_be_merge u_be_merge (
        .old_i    (rd_word),
        .new_i    (req_q.wdata),
        .be_i     (req_q.be),
        .merged_o (merged)
    );

    // Commit the merged word at the end of the response cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= merged;
        end
    end

    // Response and write-report outputs, all zero outside the response cycle.
    always_comb begin
        data_rvalid_o = rsp;
        err_o         = rsp & oor;
        wr_evt_o      = mem_we;
        data_rdata_o  = '0;
        wr_addr_o     = '0;
        wr_data_o     = '0;
        wr_be_o       = '0;
        if (rsp && !req_q.we) begin
            data_rdata_o = oor ? DMEM_OOR_DATA : rd_word;
        end
        if (mem_we) begin
            wr_addr_o = req_q.addr;
            wr_data_o = req_q.wdata;
            wr_be_o   = req_q.be;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (grant latency adapts to DMEM_RESP_WAIT_EN).
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int WC    = 1;
`ifdef DMEM_RESP_WAIT_EN
    localparam int LAT = WC;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        gnt, rvalid, err, evt;
    logic [31:0] rdata, wr_addr, wr_data;
    logic [3:0]  wr_be;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .data_req_i    (req),
        .data_gnt_o    (gnt),
        .data_rvalid_o (rvalid),
        .data_we_i     (we),
        .data_be_i     (be),
        .data_addr_i   (addr),
        .data_wdata_i  (wdata),
        .data_rdata_o  (rdata),
        .err_o         (err),
        .wr_evt_o      (evt),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .wr_be_o       (wr_be)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transfer: request, bounded wait for grant, scramble inputs, capture the response.
    task automatic xfer(input string tag, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output logic ev,
                        output logic [31:0] ea, output logic [31:0] ed, output logic [3:0] eb);
        int n;
        n = 0;
        @(posedge clk); #1;
        we = w; be = b; addr = a; wdata = d; req = 1'b1;
        @(negedge clk);
        while (!gnt && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_gnt_lat"}, 32'(n), 32'(LAT));
        @(posedge clk); #1;
        req = 1'b0; we = ~w; be = ~b; addr = ~a; wdata = ~d;
        @(negedge clk);
        chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        rd = rdata; er = err; ev = evt; ea = wr_addr; ed = wr_data; eb = wr_be;
    endtask

    logic [31:0] rd, ea, ed;
    logic        er, ev;
    logic [3:0]  eb;
    logic        b_we   [5];
    logic [31:0] b_addr [5];
    logic [31:0] b_wd   [5];
    logic [31:0] b_exp  [5];

    initial begin
        // Reset state, with a request presented that must not be granted
        req = 1'b1;
        @(negedge clk);
        chk("rst_gnt", {31'd0, gnt}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_err_evt", {30'd0, err, evt}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_wr_bus", wr_addr | wr_data | {28'd0, wr_be}, 32'd0);
        @(posedge clk); #1;
        req = 1'b0;
        rst_i = 1'b0;

        // Full write then read-back
        xfer("wr10", 1'b1, 4'hF, 32'h10, 32'hA5A5A5A5, rd, er, ev, ea, ed, eb);
        chk("wr10_evt", {31'd0, ev}, 32'd1);
        chk("wr10_addr", ea, 32'h10);
        chk("wr10_data", ed, 32'hA5A5A5A5);
        chk("wr10_be", {28'd0, eb}, 32'hF);
        chk("wr10_rdata", rd, 32'h0);
        chk("wr10_err", {31'd0, er}, 32'd0);
        @(negedge clk);
        chk("rvalid_one_cycle", {31'd0, rvalid}, 32'd0);
        xfer("rd10", 1'b0, 4'h0, 32'h10, 32'h0, rd, er, ev, ea, ed, eb);
        chk("rd10_rdata", rd, 32'hA5A5A5A5);
        chk("rd10_evt", {31'd0, ev}, 32'd0);

        // Partial write on mem[4]
        xfer("wr10b", 1'b1, 4'hF, 32'h10, 32'h11223344, rd, er, ev, ea, ed, eb);
        xfer("wr10p", 1'b1, 4'h6, 32'h10, 32'hFFFFFFFF, rd, er, ev, ea, ed, eb);
        chk("wr10p_be", {28'd0, eb}, 32'h6);
        xfer("rd10p", 1'b0, 4'h1, 32'h10, 32'h0, rd, er, ev, ea, ed, eb);
        chk("rd10p_rdata", rd, 32'h11FFFF44);

        // Byte-enable zero write is a no-op that still reports
        xfer("wr08", 1'b1, 4'hF, 32'h8, 32'h12345678, rd, er, ev, ea, ed, eb);
        xfer("wr08z", 1'b1, 4'h0, 32'h8, 32'hCAFEF00D, rd, er, ev, ea, ed, eb);
        chk("wr08z_evt", {31'd0, ev}, 32'd1);
        chk("wr08z_be", {28'd0, eb}, 32'h0);
        chk("wr08z_data", ed, 32'hCAFEF00D);
        xfer("rd08", 1'b0, 4'hF, 32'h8, 32'h0, rd, er, ev, ea, ed, eb);
        chk("rd08_rdata", rd, 32'h12345678);

        // Out-of-range accesses and the last in-range word
        xfer("wr00", 1'b1, 4'hF, 32'h0, 32'h0BADF00D, rd, er, ev, ea, ed, eb);
        xfer("rd400", 1'b0, 4'hF, 32'h400, 32'h0, rd, er, ev, ea, ed, eb);
        chk("rd400_rdata", rd, 32'hDEADBEEF);
        chk("rd400_err", {31'd0, er}, 32'd1);
        xfer("wr400", 1'b1, 4'hF, 32'h400, 32'h55555555, rd, er, ev, ea, ed, eb);
        chk("wr400_err", {31'd0, er}, 32'd1);
        chk("wr400_evt", {31'd0, ev}, 32'd0);
        chk("wr400_bus", ea | ed, 32'd0);
        xfer("rd00", 1'b0, 4'hF, 32'h0, 32'h0, rd, er, ev, ea, ed, eb);
        chk("rd00_rdata", rd, 32'h0BADF00D);
        xfer("wr3fc", 1'b1, 4'hF, 32'h3FC, 32'hFEEDFACE, rd, er, ev, ea, ed, eb);
        chk("wr3fc_err", {30'd0, er, ev}, 32'd1);
        xfer("rd3fc", 1'b0, 4'hF, 32'h3FC, 32'h0, rd, er, ev, ea, ed, eb);
        chk("rd3fc_rdata", rd, 32'hFEEDFACE);
        chk("rd3fc_err", {31'd0, er}, 32'd0);

        // Reset during the response cycle of a write aborts it
        xfer("wr20", 1'b1, 4'hF, 32'h20, 32'h13579BDF, rd, er, ev, ea, ed, eb);
        @(posedge clk); #1;
        we = 1'b1; be = 4'hF; addr = 32'h20; wdata = 32'h00000000; req = 1'b1;
        begin : abort_wait
            int n;
            n = 0;
            @(negedge clk);
            while (!gnt && n < 20) begin
                n++;
                @(negedge clk);
            end
            chk("abort_gnt_lat", 32'(n), 32'(LAT));
        end
        @(posedge clk); #1;
        req = 1'b0;
        #1;
        rst_i = 1'b1;
        @(negedge clk);
        chk("abort_rvalid", {31'd0, rvalid}, 32'd0);
        chk("abort_evt", {31'd0, evt}, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        xfer("rd20", 1'b0, 4'hF, 32'h20, 32'h0, rd, er, ev, ea, ed, eb);
        chk("rd20_rdata", rd, 32'h13579BDF);

`ifndef DMEM_RESP_WAIT_EN
        // Back-to-back with request held: one grant per cycle, read-after-write merged
        b_we   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        b_addr = '{32'h0, 32'h8, 32'h30, 32'h30, 32'h10};
        b_wd   = '{32'h0, 32'h0, 32'h89ABCDEF, 32'h0, 32'h0};
        b_exp  = '{32'h0BADF00D, 32'h12345678, 32'h0, 32'h89ABCDEF, 32'h11FFFF44};
        @(posedge clk); #1;
        req = 1'b1; be = 4'hF; we = b_we[0]; addr = b_addr[0]; wdata = b_wd[0];
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_gnt%0d", k), {31'd0, gnt}, (k < 5) ? 32'd1 : 32'd0);
            chk($sformatf("b2b_rvalid%0d", k), {31'd0, rvalid}, (k > 0) ? 32'd1 : 32'd0);
            if (k > 0) chk($sformatf("b2b_rdata%0d", k), rdata, b_exp[k-1]);
            @(posedge clk); #1;
            if (k < 4) begin
                we = b_we[k+1]; addr = b_addr[k+1]; wdata = b_wd[k+1];
            end else begin
                req = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_rvalid_end", {31'd0, rvalid}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
